// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI slave.
//   state_t        : frame FSM states
//   NBYTES_DEFAULT : default frame length in bytes
//   CMD_PREFIX     : command[7:6] value that marks an LED command
//   OFS_*          : bit offsets of the report fields inside the 40-bit shadow
//   build_shadow() : packs x/y/buttons into the 40-bit report image
package jstk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         NBYTES_DEFAULT = 5;
  localparam logic [1:0] CMD_PREFIX     = 2'b10;
  localparam int         SHADOW_BITS    = 40;

  localparam int OFS_X_LO = 32;
  localparam int OFS_X_HI = 24;
  localparam int OFS_Y_LO = 16;
  localparam int OFS_Y_HI = 8;
  localparam int OFS_BTN  = 0;

  function automatic logic [SHADOW_BITS-1:0] build_shadow(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    logic [SHADOW_BITS-1:0] s;
    s = '0;
    s[OFS_X_LO +: 8] = x[7:0];
    s[OFS_X_HI +: 2] = x[9:8];
    s[OFS_Y_LO +: 8] = y[7:0];
    s[OFS_Y_HI +: 2] = y[9:8];
    s[OFS_BTN  +: 3] = btn;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer with edge pulses on the synchronized signal.
//   clk, clr_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-clk pulses on q transitions
// RST_VAL lets slave-select idle high through reset so no false edge appears.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      q_d <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/jstk_spi_slave.sv
// SPI mode-0 slave reporting joystick X/Y/buttons and accepting an LED command.
//   clk, clr_n         : 50 MHz system clock, async active-low reset
//   x_in, y_in, btn_in : values reported in the next frame (latched at frame start)
//   sclk, ss, mosi     : SPI master pins (asynchronous, synchronized here)
//   miso, miso_oe      : slave data and its drive enable
//   led_cmd, cmd_valid : last accepted LED bits and their update pulse
//   busy               : frame in progress
//   frame_err          : pulse when a frame ends with the wrong bit count
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for slave-select fall
// ST_LOAD  | one clk: latch report shadow, drive its first bit
// ST_SHIFT | sclk rise samples mosi, sclk fall advances miso
// ST_DONE  | one clk: judge bit count and command prefix, issue pulses
module jstk_spi_slave
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NBYTES      = NBYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [2:0] btn_in,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [1:0] led_cmd,
  output logic       cmd_valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int         FRAME_BITS = 8 * NBYTES;
  localparam logic [5:0] FRAME_CNT  = 6'(FRAME_BITS);
  // Ignore edges until the synchronizers hold real pin values, so a slave
  // select that stayed low through reset is not mistaken for a new frame.
  localparam int         SETTLE     = SYNC_STAGES + 1;
  localparam int         SW         = $clog2(SETTLE + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .clr_n(clr_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .clr_n(clr_n), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .clr_n(clr_n), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  state_t                state;
  logic [FRAME_BITS-1:0] shadow;
  logic [FRAME_BITS-1:0] load_val;
  logic [7:0]            rx;
  logic [7:0]            rx_next;
  logic [7:0]            cmd;
  logic [5:0]            bit_cnt;
  logic [SW-1:0]         settle_cnt;
  logic                  settled;

  always_comb begin
    load_val = '0;
    load_val[FRAME_BITS-1 -: SHADOW_BITS] = build_shadow(x_in, y_in, btn_in);
  end

  assign rx_next = {rx[6:0], mosi_q};
  assign settled = (settle_cnt == SW'(SETTLE));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      rx         <= '0;
      cmd        <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      busy       <= 1'b0;
      led_cmd    <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (ss_fall && settled) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
          end
        end

        ST_LOAD: begin
          shadow  <= load_val;
          miso    <= load_val[FRAME_BITS-1];
          rx      <= '0;
          cmd     <= '0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          // Slave-select rise has priority over a coincident sclk edge.
          if (ss_rise) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end else if (sclk_rise) begin
            rx <= rx_next;
            if (bit_cnt == 6'd7) cmd <= rx_next;
            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          end else if (sclk_fall) begin
            // Zero fill makes miso read 0 once the report is exhausted.
            shadow <= shadow << 1;
            miso   <= shadow[FRAME_BITS-2];
          end
        end

        ST_DONE: begin
          if (bit_cnt == FRAME_CNT) begin
            if (cmd[7:6] == CMD_PREFIX) begin
              led_cmd   <= cmd[1:0];
              cmd_valid <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
          // A slave-select fall arriving during DONE starts the next frame
          // directly instead of being dropped in IDLE.
          if (ss_fall) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_sigs;
  assign unused_sigs = &{1'b0, sclk_q, ss_q, mosi_rise, mosi_fall, cmd[5:2]};

endmodule

// File: tb/tb_jstk_spi_slave.sv
module tb_jstk_spi_slave;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [9:0] x_in, y_in;
  logic [2:0] btn_in;
  logic       sclk, ss, mosi;
  logic       miso, miso_oe, cmd_valid, busy, frame_err;
  logic [1:0] led_cmd;

  always #10 clk = ~clk;

  jstk_spi_slave #(.SYNC_STAGES(SYNC), .NBYTES(5)) dut (
    .clk(clk), .clr_n(clr_n), .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .led_cmd(led_cmd), .cmd_valid(cmd_valid), .busy(busy), .frame_err(frame_err));

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_VALID = 2'b01;
  localparam logic [1:0] EV_ERR   = 2'b10;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] led;
  } ev_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [7:0]  b0;
    int          nbits;
    int          chg_bit;
    logic [9:0]  chg_x;
    logic [39:0] word;
    logic [1:0]  evt;
    logic [1:0]  led;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ev_t  sb_q[$];
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, expected 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  // Every cmd_valid/frame_err pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (cmd_valid || frame_err) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cmd_valid=%b frame_err=%b led=%b, expected none",
                 cmd_valid, frame_err, led_cmd);
      end else begin
        e = sb_q.pop_front();
        if ({frame_err, cmd_valid} !== e.kind || led_cmd !== e.led) begin
          errors++;
          $display("FAIL pulse: kind=%b led=%b expected kind=%b led=%b",
                   {frame_err, cmd_valid}, led_cmd, e.kind, e.led);
        end
      end
    end
  end

  task automatic half();
    repeat (25) @(negedge clk);
  endtask

  task automatic spi_bits(input int nbits, input logic [7:0] b0, input int chg_bit,
                          input logic [9:0] chg_x, output logic [63:0] rd);
    logic [7:0] tx;
    tx = b0;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_in = chg_x;
      mosi = tx[7];
      tx   = {tx[6:0], 1'b0};
      half();
      sclk = 1'b1;
      rd   = {rd[62:0], miso};
      half();
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  function automatic logic [63:0] exp_rd(input logic [39:0] w, input int n);
    logic [63:0] v;
    v = {24'd0, w};
    if (n <= 40) return v >> (40 - n);
    return v << (n - 40);
  endfunction

  task automatic push_ev(input logic [1:0] kind, input logic [1:0] led);
    ev_t e;
    e.kind = kind;
    e.led  = led;
    sb_q.push_back(e);
  endtask

  task automatic run_frame(input vec_t v);
    logic [63:0] rd;
    x_in   = v.x;
    y_in   = v.y;
    btn_in = v.btn;
    repeat (2) @(negedge clk);
    if (v.evt != EV_NONE) push_ev(v.evt, v.led);
    ss = 1'b0;
    spi_bits(v.nbits, v.b0, v.chg_bit, v.chg_x, rd);
    half();
    chk("busy_oe_in_frame", {busy, miso_oe}, 2'b11);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    if (v.nbits > 0) chk("read", rd, exp_rd(v.word, v.nbits));
    chk("led", led_cmd, v.led);
    chk("idle_outputs", {busy, miso_oe, miso}, 3'b000);
    chk_sb_empty("pulse_missing");
  endtask

  initial begin
    logic [63:0] rd;

    //           x       y       btn     b0     bits chg  chg_x   word               evt       led
    vecs[0]  = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 40, -1, 10'h000, 40'hA5_02_3C_01_05, EV_NONE,  2'b00};
    vecs[1]  = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, -1, 10'h000, 40'hA5_02_3C_01_05, EV_VALID, 2'b11};
    vecs[2]  = '{10'h3FF, 10'h000, 3'b111, 8'h43, 40, -1, 10'h000, 40'hFF_03_00_00_07, EV_NONE,  2'b11};
    vecs[3]  = '{10'h000, 10'h3FF, 3'b000, 8'h81, 40, -1, 10'h000, 40'h00_00_FF_03_00, EV_VALID, 2'b01};
    vecs[4]  = '{10'h155, 10'h2AA, 3'b010, 8'h80, 23, -1, 10'h000, 40'h55_01_AA_02_02, EV_ERR,   2'b01};
    vecs[5]  = '{10'h155, 10'h2AA, 3'b010, 8'h82, 40, -1, 10'h000, 40'h55_01_AA_02_02, EV_VALID, 2'b10};
    vecs[6]  = '{10'h155, 10'h2AA, 3'b010, 8'h83,  0, -1, 10'h000, 40'h55_01_AA_02_02, EV_ERR,   2'b10};
    vecs[7]  = '{10'h0AB, 10'h300, 3'b001, 8'h81, 41, -1, 10'h000, 40'hAB_00_00_03_01, EV_ERR,   2'b10};
    vecs[8]  = '{10'h1C3, 10'h07E, 3'b100, 8'h82,  8, -1, 10'h000, 40'hC3_01_7E_00_04, EV_ERR,   2'b10};
    vecs[9]  = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 40, 12, 10'h0F0, 40'hA5_02_3C_01_05, EV_NONE,  2'b10};
    vecs[10] = '{10'h0F0, 10'h13C, 3'b101, 8'hC1, 40, -1, 10'h000, 40'hF0_00_3C_01_05, EV_NONE,  2'b10};

    clr_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_in = '0; y_in = '0; btn_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {miso, miso_oe, busy, cmd_valid, frame_err, led_cmd}, 7'd0);
    clr_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", {busy, miso_oe, miso, led_cmd}, 5'd0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // First-bit latency and exact cmd_valid timing after slave-select rise.
    x_in = 10'h2A5; y_in = 10'h13C; btn_in = 3'b101;
    repeat (2) @(negedge clk);
    push_ev(EV_VALID, 2'b11);
    ss = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    chk("first_bit_latency", miso, 1'b1);
    spi_bits(40, 8'h83, -1, 10'h000, rd);
    half();
    ss = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("cmd_valid_timing", cmd_valid, (k == SYNC + 2));
    end
    repeat (4) @(negedge clk);
    chk("read_latency_frame", rd, exp_rd(40'hA5_02_3C_01_05, 40));
    chk("led_latency_frame", led_cmd, 2'b11);
    chk_sb_empty("pulse_missing_latency");

    // Back-to-back frames: slave select high for a single clk between them.
    push_ev(EV_VALID, 2'b01);
    push_ev(EV_VALID, 2'b10);
    ss = 1'b0;
    spi_bits(40, 8'h81, -1, 10'h000, rd);
    half();
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    spi_bits(40, 8'h82, -1, 10'h000, rd);
    half();
    ss = 1'b1;
    repeat (8) @(negedge clk);
    chk("read_back_to_back", rd, exp_rd(40'hA5_02_3C_01_05, 40));
    chk("led_back_to_back", led_cmd, 2'b10);
    chk_sb_empty("pulse_missing_back_to_back");

    // Reset in the middle of a frame, then a clean frame.
    ss = 1'b0;
    spi_bits(17, 8'h82, -1, 10'h000, rd);
    clr_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_frame", {miso, miso_oe, busy, cmd_valid, frame_err, led_cmd}, 7'd0);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    clr_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_mid_reset", {busy, miso_oe, led_cmd}, 4'd0);
    chk_sb_empty("no_pulse_after_reset");
    run_frame('{10'h2A5, 10'h13C, 3'b101, 8'h81, 40, -1, 10'h000,
                40'hA5_02_3C_01_05, EV_VALID, 2'b01});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jstk_spi_slave.md
JSTK_SPI_SLAVE -- requirements
Module: jstk_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, ss and mosi.
REQ-002 Parameter NBYTES, default 5: frame length in bytes.
REQ-003 Port clk, input, 1: single system clock, 50 MHz; the block has no other clock.
REQ-004 Port clr_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port x_in, input, 10: joystick X value to report.
REQ-006 Port y_in, input, 10: joystick Y value to report.
REQ-007 Port btn_in, input, 3: {btn2, btn1, trigger} status to report.
REQ-008 Port sclk, input, 1: SPI clock from master, mode 0, at most clk/8.
REQ-009 Port ss, input, 1: slave select from master, active-low.
REQ-010 Port mosi, input, 1: master-to-slave data.
REQ-011 Port miso, output, 1: slave-to-master data; 0 when not selected.
REQ-012 Port miso_oe, output, 1: MISO drive enable; 1 only while ss is low.
REQ-013 Port led_cmd, output, 2: last accepted LED command bits.
REQ-014 Port cmd_valid, output, 1: one-clk pulse when led_cmd updates.
REQ-015 Port busy, output, 1: high from synchronized ss fall to synchronized ss rise.
REQ-016 Port frame_err, output, 1: one-clk pulse when a frame ends with bit count != 8*NBYTES.

Function
REQ-017 sclk, ss and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals.
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-019 IDLE -> LOAD on synchronized ss fall; LOAD SHALL last one clk, then -> SHIFT.
REQ-020 LOAD SHALL latch the 40-bit shadow {x_in[7:0], 6'b0, x_in[9:8], y_in[7:0], 6'b0, y_in[9:8], 5'b0, btn_in}; inputs SHALL NOT affect the frame after LOAD.
REQ-021 miso SHALL present shadow bit 39 by the end of LOAD, i.e. at most SYNC_STAGES+2 clk after the ss pin falls.
REQ-022 In SHIFT, each synchronized sclk rise SHALL shift mosi into an 8-bit rx register, MSB first, and increment a 6-bit bit counter.
REQ-023 In SHIFT, each synchronized sclk fall SHALL advance miso to the next shadow bit, MSB first.
REQ-024 After 40 bits, miso SHALL be 0; the bit counter SHALL saturate at 63.
REQ-025 The byte captured at bit count 8 SHALL be held as the command byte; later rx bytes are discarded.
REQ-026 SHIFT -> DONE on synchronized ss rise; DONE SHALL last one clk, then -> IDLE.
REQ-027 In DONE with count == 40 and command[7:6] == 2'b10, led_cmd <= command[1:0] and cmd_valid SHALL pulse.
REQ-028 In DONE with count == 40 and any other prefix, led_cmd SHALL hold; no pulse on either cmd_valid or frame_err.
REQ-029 In DONE with count != 40, including 0, frame_err SHALL pulse and led_cmd SHALL hold.
REQ-030 When an sclk edge and an ss rise are detected in the same clk, the ss rise SHALL win and the edge SHALL be ignored.
REQ-031 An ss fall detected in DONE SHALL be taken on the clk after DONE, with no frame lost.

Reset
REQ-032 While clr_n is low: state IDLE; miso, miso_oe, busy, cmd_valid, frame_err, led_cmd, counters, shadow and synchronizers all 0; ss synchronizer preset to 1.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no cmd_valid or frame_err pulse; after release, the block SHALL wait for a fresh ss fall.

Structure
REQ-034 Package jstk_pkg SHALL hold the FSM state type, NBYTES_DEFAULT = 5, CMD_PREFIX = 2'b10 and the shadow field offsets.
REQ-035 One sub-module, sync_edge (N-flop synchronizer with rise/fall pulses), SHALL be instantiated for sclk and ss; mosi uses its data output only.

Verification
REQ-036 x_in=10'h2A5, y_in=10'h13C, btn_in=3'b101; 40-bit mode-0 frame at clk/50 -> master reads 40'hA5_02_3C_01_05.
REQ-037 MOSI byte0 = 8'h83 in a 40-bit frame -> led_cmd=2'b11, one cmd_valid pulse 2 clk after ss sync rise.
REQ-038 MOSI byte0 = 8'h43 -> led_cmd unchanged, no cmd_valid, no frame_err.
REQ-039 ss raised after 23 bits -> frame_err single pulse, led_cmd unchanged, busy low, back in IDLE.
REQ-040 x_in changed mid-frame -> frame data unchanged; the next frame reports the new value.
REQ-041 clr_n low at bit 17, then a full 40-bit frame with byte0 = 8'h81 -> no pulses during reset, then led_cmd=2'b01.
